// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit saturating counter encoding
// and a helper that extracts the taken/not-taken decision from a counter.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic logic ctr_taken(input ctr_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-resolve signals of the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 64
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic             if_is_branch;
    logic [WIDTH-1:0] if_pc;
    logic [WIDTH-1:0] if_imm;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;
    logic [IDX_W-1:0] pred_idx;

    logic             ex_valid;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] ex_target;
    logic [IDX_W-1:0] ex_idx;
    logic             ex_pred_taken;
    logic             ex_compare_result;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;

    modport master (
        output if_pc, if_is_branch, if_imm,
        output ex_valid, ex_pc, ex_target, ex_idx, ex_pred_taken, ex_compare_result,
        input  pred_taken, pred_target, pred_idx, redirect, redirect_pc
    );

    modport slave (
        input  if_pc, if_is_branch, if_imm,
        input  ex_valid, ex_pc, ex_target, ex_idx, ex_pred_taken, ex_compare_result,
        output pred_taken, pred_target, pred_idx, redirect, redirect_pc
    );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-state of one 2-bit saturating counter given the resolved outcome.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t cur,
    input  logic taken,
    output ctr_t nxt
);

    always_comb begin
        nxt = cur;
        if (taken)
            nxt = (cur == ST) ? ST : ctr_t'(cur + 2'd1);
        else
            nxt = (cur == SNT) ? SNT : ctr_t'(cur - 2'd1);
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal 2-bit-counter branch predictor with registered mispredict redirect.
// Define BP_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 64
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);

    localparam int IDX_W = $clog2(ENTRIES);

    ctr_t             cnt_q [ENTRIES];
    logic             redirect_q;
    logic [WIDTH-1:0] redirect_pc_q;

    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] lk_idx;
    logic             accept;
    logic             mispredict;
    ctr_t             ctr_nxt;

    assign pc_idx = bp.if_pc[IDX_W+1:2];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    assign lk_idx = pc_idx ^ ghr_q;
`else
    assign lk_idx = pc_idx;
`endif

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    assign bp.pred_idx    = lk_idx;
    assign bp.pred_taken  = bp.if_is_branch & ctr_taken(cnt_q[lk_idx]);
    assign bp.pred_target = bp.if_pc + bp.if_imm;

    // A resolve arriving during the redirect cycle is wrong-path and dropped.
    assign accept     = bp.ex_valid & ~redirect_q;
    assign mispredict = accept & (bp.ex_compare_result != bp.ex_pred_taken);

    bp_sat_counter u_ctr (
        .cur   (cnt_q[bp.ex_idx]),
        .taken (bp.ex_compare_result),
        .nxt   (ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_q[i] <= WNT;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
`ifdef BP_GSHARE_EN
            ghr_q         <= '0;
`endif
        end else begin
            redirect_q <= mispredict;
            if (mispredict)
                redirect_pc_q <= bp.ex_compare_result ? bp.ex_target
                                                      : bp.ex_pc + WIDTH'(4);
            if (accept) begin
                cnt_q[bp.ex_idx] <= ctr_nxt;
`ifdef BP_GSHARE_EN
                ghr_q <= {ghr_q[IDX_W-2:0], bp.ex_compare_result};
`endif
            end
        end
    end

    assign bp.redirect    = redirect_q;
    assign bp.redirect_pc = redirect_pc_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data/PC width.
REQ-002 SHALL have parameter ENTRIES, default 64: pattern-table entries, power of two, IDX_W = log2(ENTRIES).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port if_pc  input  WIDTH  fetch-stage PC for lookup.
REQ-006 SHALL have port if_is_branch  input  1  predecode flag: fetched instruction is a conditional branch.
REQ-007 SHALL have port if_imm  input  WIDTH  sign-extended B-type offset.
REQ-008 SHALL have port pred_taken  output  1  prediction for the fetched branch.
REQ-009 SHALL have port pred_target  output  WIDTH  if_pc + if_imm.
REQ-010 SHALL have port pred_idx  output  IDX_W  table index used, carried down the pipeline.
REQ-011 SHALL have port ex_valid  input  1  a branch resolves in EX this cycle.
REQ-012 SHALL have port ex_pc, ex_target  input  WIDTH  resolving branch PC and computed target.
REQ-013 SHALL have port ex_idx  input  IDX_W  pred_idx carried with the branch.
REQ-014 SHALL have port ex_pred_taken  input  1  prediction carried with the branch.
REQ-015 SHALL have port ex_compare_result  input  1  actual outcome from the branch comparator (1 = taken).
REQ-016 SHALL have port redirect  output  1  registered mispredict pulse / pipeline flush.
REQ-017 SHALL have port redirect_pc  output  WIDTH  correct fetch PC when redirect = 1.

Function
REQ-018 Table of ENTRIES 2-bit saturating counters: SNT=00, WNT=01, WT=10, ST=11.
REQ-019 Lookup combinational: pred_idx = if_pc[IDX_W+1:2]; pred_taken = if_is_branch AND counter[pred_idx][1].
REQ-020 pred_target = if_pc + if_imm, modulo 2^WIDTH, regardless of if_is_branch.
REQ-021 Accepted update = ex_valid AND NOT redirect; counter[ex_idx] increments (taken) or decrements (not taken) at the next edge, saturating at ST/SNT.
REQ-022 Same-cycle lookup and update to the same index: lookup returns the pre-update value.
REQ-023 Mispredict = accepted update AND (ex_compare_result != ex_pred_taken).
REQ-024 redirect asserted exactly one cycle after a mispredict, for one cycle; redirect_pc = ex_target if actually taken, else ex_pc + 4.
REQ-025 ex_valid while redirect = 1 is wrong-path: ignored (no table, history or redirect change).
REQ-026 redirect_pc holds its last value when redirect = 0.

Reset
REQ-027 While rst = 1 at a clock edge: all counters <- WNT, redirect <- 0, redirect_pc <- 0, history (if present) <- 0.
REQ-028 Reset asserted mid-operation overrides any concurrent update or pending redirect.
REQ-029 Combinational outputs follow the reset table state from the cycle after reset.

Configuration
REQ-030 Macro BP_GSHARE_EN defined: IDX_W-bit global history register; pred_idx = if_pc[IDX_W+1:2] XOR ghr; each accepted update shifts ex_compare_result into ghr LSB.
REQ-031 Macro BP_GSHARE_EN undefined: no history register; indexing per REQ-019.

Structure
REQ-032 Shared package bp_pkg holds counter encodings SNT/WNT/WT/ST and the 2-bit counter type.
REQ-033 One sub-module bp_sat_counter: combinational next-state of a 2-bit counter given the outcome.
REQ-034 Table implemented as flops (reset-initialised), no RAM macro.

Verification
REQ-035 After reset, if_pc=0x100, if_is_branch=1 -> pred_taken=0, pred_idx=0x00, pred_target=if_pc+if_imm.
REQ-036 Two accepted taken updates, ex_idx=5, ex_pred_taken=0 -> counter 01->10->11; first update gives redirect=1 next cycle with redirect_pc=ex_target; second update is ignored (it falls in the redirect cycle) unless spaced by one idle cycle.
REQ-037 Counter at ST, three not-taken updates spaced apart -> 11->10->01->00, then a fourth stays 00.
REQ-038 ex_pred_taken=1, ex_compare_result=0, ex_pc=0x2000 -> redirect=1 next cycle, redirect_pc=0x2004, then 0.
REQ-039 Lookup and update same index same cycle (counter WNT, taken) -> pred_taken=0 that cycle, 1 next cycle.
REQ-040 rst asserted in the cycle following a mispredict -> redirect=0, all counters WNT; with BP_GSHARE_EN, ghr=0 and pred_idx equals PC bits.
